// File: rtl/uart_frame_receiver_pkg.sv
// Shared frame constants and state type for the 8N2 UART frame receiver.
package uart_frame_receiver_pkg;

    localparam int FRAME_BITS = 11;   // start + 8 data + 2 stop
    localparam int DATA_BITS  = 8;
    localparam int START_IDX  = 1;
    localparam int STOP1_IDX  = 10;
    localparam int STOP2_IDX  = 11;
    localparam int BIT_IDX_W  = 4;    // holds bit indices 1..11

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Receiver-side signal bundle: serial line in, frame status and captured bits out.
// OK acts as a one-cycle valid for sample; there is no ready, so the consumer
// must take sample[9:2] in the cycle OK is high (it stays stable until the
// next frame's first sampling edge anyway).
interface uart_frame_receiver_if;
    import uart_frame_receiver_pkg::*;

    logic                 RX;
    logic                 OK;
    logic                 catch;
    logic [FRAME_BITS:1]  sample;
    rx_state_t            dbg_state;

    modport slave  (input  RX, output OK, catch, sample, dbg_state);
    modport master (output RX, input  OK, catch, sample, dbg_state);

endinterface

// File: rtl/uart_frame_receiver.sv
// 8N2 UART frame receiver: start detect on idle-high line, mid-bit sampling of
// 11 bit-times, parallel capture of all bits, single-cycle OK on a clean frame.
module uart_frame_receiver
    import uart_frame_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5,
    parameter int COUNT_W      = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_frame_receiver_if.slave  bus
);

    // Offset of the bit centre inside one bit period.
    localparam int H = CLKS_PER_BIT / 2;

    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    logic [COUNT_W-1:0]      r_count;
    logic [COUNT_W-1:0]      w_count_nxt;
    logic [BIT_IDX_W-1:0]    r_bit_k;
    logic [BIT_IDX_W-1:0]    w_bit_k_nxt;
    logic [FRAME_BITS:1]     r_sample;
    logic [FRAME_BITS:1]     w_sample_nxt;
    logic                    r_ok;
    logic                    w_ok_nxt;
    logic [COUNT_W-1:0]      w_tick_count;
    logic                    w_tick;

    // Frame-clock value at which the bit currently awaited is at its centre.
    assign w_tick_count = COUNT_W'(CLKS_PER_BIT * (int'(r_bit_k) - 1) + H);
    assign w_tick       = (r_state == ST_BUSY) && (r_count == w_tick_count);

    // Next-state, counter, capture and OK decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_bit_k_nxt  = r_bit_k;
        w_sample_nxt = r_sample;
        w_ok_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.RX) begin
                    w_state_nxt = ST_BUSY;
                    w_count_nxt = '0;
                    w_bit_k_nxt = BIT_IDX_W'(START_IDX);
                end
            end
            ST_BUSY: begin
                w_count_nxt = r_count + 1'b1;
                if (w_tick) begin
                    for (int k = START_IDX; k <= STOP2_IDX; k++) begin
                        if (r_bit_k == BIT_IDX_W'(k)) begin
                            w_sample_nxt[k] = bus.RX;
                        end
                    end
                    if ((r_bit_k == BIT_IDX_W'(START_IDX)) && bus.RX) begin
                        // Start bit was a glitch: drop back to idle silently.
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                    end else if (r_bit_k == BIT_IDX_W'(STOP2_IDX)) begin
                        // Second stop bit ends the frame; RX is used live
                        // because sample[11] only lands on this same edge.
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                        w_ok_nxt    = !r_sample[START_IDX] && r_sample[STOP1_IDX] && bus.RX;
                    end else begin
                        w_bit_k_nxt = r_bit_k + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // State, frame counter, capture register and OK pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_bit_k  <= '0;
            r_sample <= '0;
            r_ok     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_bit_k  <= w_bit_k_nxt;
            r_sample <= w_sample_nxt;
            r_ok     <= w_ok_nxt;
        end
    end

    assign bus.catch     = (r_state == ST_BUSY);
    assign bus.OK        = r_ok;
    assign bus.sample    = r_sample;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for the 8N2 UART frame receiver: directed scenarios plus random frames,
// compared every cycle against an edge-indexed behavioural model.
module tb_uart_frame_receiver;
    import uart_frame_receiver_pkg::*;

    localparam int C = 5;
    localparam int H = C / 2;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_frame_receiver_if bus();

    uart_frame_receiver #(.CLKS_PER_BIT(C), .COUNT_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int ok_seen = 0;
    logic [7:0] ok_log[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works in edges since start detect: bit k is read at edge (k-1)*C + H + 1.
    int          m_busy = 0;
    int          m_start = 0;
    int          edge_n = 0;
    int          m_off;
    int          m_k;
    logic [11:1] m_sample = '0;
    logic        m_ok = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy   = 0;
            m_start  = 0;
            edge_n   = 0;
            m_sample = '0;
            m_ok     = 1'b0;
            exp_q.delete();
        end else begin
            edge_n++;
            m_ok = 1'b0;
            if (m_busy == 0) begin
                if (bus.RX == 1'b0) begin
                    m_busy  = 1;
                    m_start = edge_n;
                end
            end else begin
                m_off = edge_n - m_start - 1 - H;
                if (m_off >= 0 && (m_off % C) == 0) begin
                    m_k = m_off / C + 1;
                    m_sample[m_k] = bus.RX;
                    if (m_k == 1 && bus.RX == 1'b1) begin
                        m_busy = 0;
                    end else if (m_k == 11) begin
                        m_busy = 0;
                        m_ok = (m_sample[1] == 1'b0) && m_sample[10] && m_sample[11];
                        if (m_ok) exp_q.push_back(m_sample[9:2]);
                    end
                end
            end
        end
    end

    // ---------------- compare / scoreboard ----------------
    logic [7:0] sb_d;
    always @(negedge CLK) begin
        if (!RST) begin
            check("catch", 16'(bus.catch), 16'(m_busy != 0));
            check("ok", 16'(bus.OK), 16'(m_ok));
            check("sample", 16'(bus.sample), 16'(m_sample));
            if (bus.OK) begin
                ok_seen++;
                ok_log.push_back(bus.sample[9:2]);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_ok", 16'(1), 16'(0));
                end else begin
                    sb_d = exp_q.pop_front();
                    check("sb_data", 16'(bus.sample[9:2]), 16'(sb_d));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        bus.RX = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic s1, input logic s2,
                              input int stop2_cycles);
        logic [11:1] bits;
        bits = {s2, s1, data, 1'b0};
        for (int k = 1; k <= 11; k++) begin
            bus.RX = bits[k];
            repeat ((k == 11) ? stop2_cycles : C) @(negedge CLK);
        end
    endtask

    // ---------------- stimulus ----------------
    int ok_before;
    logic [7:0] rd;
    logic rs1, rs2;

    initial begin
        bus.RX = 1'b1;
        RST = 1'b1;
        #2 RST = 1'b0;

        // Directed 0x55 frame with absolute timing.
        #21 bus.RX = 1'b0;                       // t=23
        #3  check("t26_catch", 16'(bus.catch), 16'(1));
        #47 bus.RX = ~bus.RX;                    // t=73
        repeat (8) #50 bus.RX = ~bus.RX;         // last toggle t=473
        #83;                                     // t=556
        check("t556_ok", 16'(bus.OK), 16'(1));
        check("t556_catch", 16'(bus.catch), 16'(0));
        check("t556_sample", 16'(bus.sample), 16'(11'b110_1010_1010));
        check("t556_data", 16'(bus.sample[9:2]), 16'h55);
        #10 check("t566_ok_drop", 16'(bus.OK), 16'(0));
        idle_cycles(4);

        // Glitch: one clock of low line.
        ok_before = ok_seen;
        @(negedge CLK) bus.RX = 1'b0;
        @(negedge CLK) bus.RX = 1'b1;
        check("glitch_catch", 16'(bus.catch), 16'(1));
        idle_cycles(8);
        check("glitch_start_bit", 16'(bus.sample[1]), 16'(1));
        check("glitch_no_ok", 16'(ok_seen), 16'(ok_before));

        // Framing error on stop1.
        send_frame(8'hA3, 1'b0, 1'b1, C);
        idle_cycles(3);
        check("ferr_catch", 16'(bus.catch), 16'(0));
        check("ferr_stop1", 16'(bus.sample[10]), 16'(0));
        check("ferr_data", 16'(bus.sample[9:2]), 16'hA3);
        check("ferr_no_ok", 16'(ok_seen), 16'(ok_before));

        // Reset mid-frame, after the D3 sample.
        bus.RX = 1'b0;
        repeat (C) @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            bus.RX = k[0];
            repeat (C) @(negedge CLK);
        end
        #2 RST = 1'b1;
        #1;
        check("rst_catch", 16'(bus.catch), 16'(0));
        check("rst_ok", 16'(bus.OK), 16'(0));
        check("rst_sample", 16'(bus.sample), 16'(0));
        check("rst_state", 16'(bus.dbg_state), 16'(ST_IDLE));
        bus.RX = 1'b1;
        #1 RST = 1'b0;
        idle_cycles(3);
        send_frame(8'hC4, 1'b1, 1'b1, C);
        idle_cycles(2);
        check("post_rst_ok", 16'(ok_seen), 16'(ok_before + 1));
        check("post_rst_data", 16'(bus.sample[9:2]), 16'hC4);

        // Back-to-back: next start lands on the edge after frame end.
        ok_before = ok_seen;
        send_frame(8'h00, 1'b1, 1'b1, H + 2);
        send_frame(8'hFF, 1'b1, 1'b1, C);
        idle_cycles(3);
        check("b2b_count", 16'(ok_seen), 16'(ok_before + 2));
        if (ok_log.size() >= 2) begin
            check("b2b_first", 16'(ok_log[ok_log.size() - 2]), 16'h00);
            check("b2b_second", 16'(ok_log[ok_log.size() - 1]), 16'hFF);
        end else begin
            check("b2b_log_size", 16'(ok_log.size()), 16'(2));
        end

        // Idle line.
        ok_before = ok_seen;
        idle_cycles(200);
        check("idle_catch", 16'(bus.catch), 16'(0));
        check("idle_no_ok", 16'(ok_seen), 16'(ok_before));
        check("idle_sample_kept", 16'(bus.sample[9:2]), 16'hFF);

        // Random frames, stop-bit errors and glitches.
        for (int i = 0; i < 40; i++) begin
            rd  = 8'($urandom_range(0, 255));
            rs1 = ($urandom_range(0, 9) != 0);
            rs2 = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) begin
                bus.RX = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
                idle_cycles(C + 1);
            end
            send_frame(rd, rs1, rs2, $urandom_range(0, 1) ? C : H + 2);
            idle_cycles($urandom_range(C + 1, C + 6));
        end
        idle_cycles(4 * C);

        check("exp_q_drained", 16'(exp_q.size()), 16'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Serial UART receiver for an 8N2 frame: start bit, D0..D7 LSB first, two stop bits, 11 bit-times in total.
- Detects a start bit on the idle-high RX line, samples each bit near its centre, and exposes the 11 captured bits in parallel.
- Pulses OK when a frame completes with valid start and stop bits.
- Sits between the board RX pin and command decoding logic; the decoder reads data from sample[9:2].

Parameters:
- CLKS_PER_BIT, 5, CLK cycles per bit period (>=2); 11*CLKS_PER_BIT must fit in COUNT_W bits.
- COUNT_W, 6, width of the internal frame clock counter (count).

Ports:
- CLK  input  1  system clock, rising edge active.
- RST  input  1  asynchronous, active-high reset.
- RX  input  1  serial line; idle high; already synchronous to CLK.
- OK  output  1  one-cycle pulse: frame received with start=0 and both stops=1.
- catch  output  1  high while a frame is being received (busy).
- sample  output  11  captured bits: [1]=start, [9:2]=D0..D7, [10]=stop1, [11]=stop2.

Behaviour:
- Reset (RST high, asynchronous): catch=0, OK=0, sample=0, count=0. Reset asserted mid-frame aborts the frame with no OK.
- Idle (catch=0):
  - On a rising CLK edge with RX=0: catch<=1, count<=0. This is the start-detect edge.
  - Otherwise nothing changes and sample holds its last value.
- Busy (catch=1): count increments by 1 on every edge.
- Define H = CLKS_PER_BIT/2 (integer division; 2 for the default).
- Bit sampling: on the edge where the pre-edge count equals (k-1)*CLKS_PER_BIT + H, for k=1..11, sample[k]<=RX. Other sample bits are untouched.
- False start: if the k=1 sample reads RX=1, the receiver aborts. On that edge catch<=0 and count<=0; OK is not pulsed. sample[1] still records the 1.
- Frame end, on the k=11 sample edge:
  - catch<=0 and count<=0.
  - OK<=1 only if sample[1]==0, sample[10]==1 and the current RX==1.
  - OK is high for exactly one cycle, then returns to 0.
- Framing error (either stop bit 0): catch drops as normal, OK stays 0, sample holds the bad bits.
- Back-to-back frames: a start can be detected on the edge immediately after the frame-end edge.
- catch and OK are registered outputs. sample changes only on sampling edges.
- Latency from the start-detect edge to OK: 10*CLKS_PER_BIT + H + 1 edges (53 with the defaults).

Decomposition:
- Shared package: frame constants FRAME_BITS=11, DATA_BITS=8, START_IDX=1, STOP1_IDX=10, STOP2_IDX=11.
- Single module; no sub-module is needed.
- A bit-tick helper (count compare) may be inlined.

Test Plan:
- Clock period 10 (first rising edge at 5). Set RX=1, fall at t=23, toggle every 50 nine times, then hold 1 (data 0x55).
  - Required: catch rises at the edge at 25.
  - Sampling edges at 55, 105, ..., 555.
  - At 555: OK=1 for one cycle, catch=0, sample=11'b110_1010_1010, sample[9:2]=0x55.
- Glitch: RX low for 10 time units only, then high → catch pulses, no OK, sample[1]=1.
- Framing error: send 0xA3 with stop1=0 → no OK, catch drops at the k=11 edge, sample[10]=0, sample[9:2]=0xA3.
- Assert RST mid-frame (after the D3 sample) → catch=0, count=0, sample=0 immediately, before the next clock edge. The next full frame receives correctly.
- Back-to-back frames 0x00 then 0xFF, the second start beginning right after stop2 → two OK pulses, sample[9:2]=0x00 then 0xFF.
- Idle-high line for 200 cycles → catch and OK stay 0, sample unchanged.
